// File: rtl/qu_uop_dispatch.sv
// -----------------------------------------------------------------------------
// qu_uop package and qu_uop_dispatch
//
// qu_uop:
//   Packed micro-op layout shared by rename, the dispatch buffer and the issue
//   queues, plus optype classification helpers. Bits [3:0] of every uop hold
//   the optype; the remaining fields are reinterpreted per issue port.
//
// qu_uop_dispatch:
//   In-order dispatch buffer between rename and the issue queues. Uops are
//   held in a small FIFO. The head entry is steered to either the
//   integer/control port or the load/store port by its optype. A head with an
//   illegal optype is dropped and reported with a one-cycle pulse.
//
// Ports:
//   clk           in   clock
//   rst_n         in   synchronous active-low reset
//   flush         in   discard all buffered uops
//   in_valid      in   rename presents a uop
//   in_ready      out  buffer can accept a uop this cycle
//   in_uop        in   packed uop_t from rename
//   ic_valid      out  head uop is INT, BRANCH or CONT
//   ic_ready      in   integer/control issue queue accepts
//   ic_uop        out  head uop (uop_ic view)
//   ldst_valid    out  head uop is LOAD or STORE
//   ldst_ready    in   load/store issue queue accepts
//   ldst_uop      out  head uop (uop_ldst view)
//   ldst_is_store out  head is a STORE, qualified by ldst_valid
//   bad_optype    out  one-cycle pulse: an illegal-optype head was dropped
//   count         out  current occupancy
// -----------------------------------------------------------------------------

package qu_uop;

  localparam int UOP_WIDTH = 32;

  typedef enum logic [3:0] {
    OPTYPE_INT    = 4'b0001,
    OPTYPE_BRANCH = 4'b0011,
    OPTYPE_CONT   = 4'b0111,
    OPTYPE_LOAD   = 4'b1001,
    OPTYPE_STORE  = 4'b0101
  } optype_e;

  // Generic view as produced by rename.
  typedef struct packed {
    logic [15:0] imm;
    logic [5:0]  rd;
    logic [5:0]  rs;
    logic [3:0]  optype;
  } uop_t;

  // Integer/control issue view.
  typedef struct packed {
    logic [15:0] imm;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [3:0]  optype;
  } uop_ic;

  // Load/store issue view: imm is the address offset, rd is the load
  // destination or the store data register.
  typedef struct packed {
    logic [15:0] offset;
    logic [5:0]  rd_or_data;
    logic [5:0]  base;
    logic [3:0]  optype;
  } uop_ldst;

  // True for optypes that go to the integer/control issue queue.
  function automatic logic is_ic_optype(input logic [3:0] op);
    logic r;
    case (op)
      4'b0001: r = 1'b1;
      4'b0011: r = 1'b1;
      4'b0111: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // True for optypes that go to the load/store issue queue.
  function automatic logic is_ldst_optype(input logic [3:0] op);
    logic r;
    case (op)
      4'b1001: r = 1'b1;
      4'b0101: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // True only for a store optype.
  function automatic logic is_store_optype(input logic [3:0] op);
    return (op == 4'b0101);
  endfunction

endpackage


module qu_uop_dispatch #(
  parameter int DEPTH     = 4,
  parameter int UOP_WIDTH = qu_uop::UOP_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [UOP_WIDTH-1:0]       in_uop,
  output logic                       ic_valid,
  input  logic                       ic_ready,
  output logic [UOP_WIDTH-1:0]       ic_uop,
  output logic                       ldst_valid,
  input  logic                       ldst_ready,
  output logic [UOP_WIDTH-1:0]       ldst_uop,
  output logic                       ldst_is_store,
  output logic                       bad_optype,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Storage and state
  logic [UOP_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_bad_optype;

  // Combinational control
  logic [UOP_WIDTH-1:0] w_head;
  logic [3:0]           w_optype;
  logic                 w_active;
  logic                 w_head_ic;
  logic                 w_head_ldst;
  logic                 w_head_store;
  logic                 w_illegal;
  logic                 w_ic_valid;
  logic                 w_ldst_valid;
  logic                 w_in_ready;
  logic                 w_push;
  logic                 w_pop;

  assign w_head   = r_mem[r_rd_ptr];
  assign w_optype = w_head[3:0];

  // Classify the head entry and derive handshake qualifiers.
  always_comb begin
    w_active     = 1'b0;
    w_head_ic    = 1'b0;
    w_head_ldst  = 1'b0;
    w_head_store = 1'b0;
    w_illegal    = 1'b0;
    w_ic_valid   = 1'b0;
    w_ldst_valid = 1'b0;
    w_in_ready   = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;

    // The head is only meaningful when something is buffered and the
    // pipeline is neither being reset nor flushed this cycle.
    if ((r_count != CNT_ZERO) && !flush && rst_n) begin
      w_active = 1'b1;
    end else begin
      w_active = 1'b0;
    end

    w_head_ic    = qu_uop::is_ic_optype(w_optype);
    w_head_ldst  = qu_uop::is_ldst_optype(w_optype);
    w_head_store = qu_uop::is_store_optype(w_optype);

    w_ic_valid   = w_active && w_head_ic;
    w_ldst_valid = w_active && w_head_ldst;
    // An illegal head is retired unconditionally so it cannot stall the pipe.
    w_illegal    = w_active && !w_head_ic && !w_head_ldst;

    // Push is blocked at full even if a pop happens in the same cycle; this
    // keeps in_ready independent of the downstream ready inputs.
    w_in_ready = (r_count != CNT_FULL) && !flush && rst_n;
    w_push     = in_valid && w_in_ready;
    w_pop      = (w_ic_valid && ic_ready) || (w_ldst_valid && ldst_ready) || w_illegal;
  end

  // Write the pushed uop into the array; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_uop;
    end
  end

  // Pointers, occupancy and the illegal-drop pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= PTR_ZERO;
      r_rd_ptr     <= PTR_ZERO;
      r_count      <= CNT_ZERO;
      r_bad_optype <= 1'b0;
    end else if (flush) begin
      r_wr_ptr     <= PTR_ZERO;
      r_rd_ptr     <= PTR_ZERO;
      r_count      <= CNT_ZERO;
      r_bad_optype <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      r_bad_optype <= w_illegal;
    end
  end

  assign in_ready      = w_in_ready;
  assign ic_valid      = w_ic_valid;
  assign ldst_valid    = w_ldst_valid;
  assign ic_uop        = w_head;
  assign ldst_uop      = w_head;
  assign ldst_is_store = w_ldst_valid && w_head_store;
  assign bad_optype    = r_bad_optype;
  assign count         = r_count;

endmodule
